sync_fifo_param: RTL and testbench

//   Parametrised single-clock synchronous FIFO for data buffering between producer/consumer logic.

---
 rtl/sync_fifo_param.sv | 106 ++++++++++
 tb/tb_sync_fifo_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock synchronous FIFO with flush, occupancy count, almost-full/empty thresholds,
// per-cycle ack/overflow/underflow pulses and selectable standard or FWFT read.
module sync_fifo_param #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1,
    parameter bit          FWFT      = 1'b0,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almostfull,
    output logic             almostempty,
    output logic [CW-1:0]    count,
    output logic             wr_ack,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_ack_q, overflow_q, underflow_q;
    logic             wr_acc, rd_acc;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Flush suppresses acceptance so neither memory nor pointers move in that cycle.
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                if (!FWFT) begin
                    dout_d = mem[rd_ptr_q];
                end
            end
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && full && !flush;
            underflow_q <= rd_en && empty && !flush;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // FWFT presents the head combinationally; drive zero while empty to keep it tidy.
    assign data_out    = FWFT ? (empty ? '0 : mem[rd_ptr_q]) : dout_q;
    assign count       = count_q;
    assign almostfull  = (count_q >= CW'(AF_THRESH)) && !full;
    assign almostempty = (count_q <= CW'(AE_THRESH)) && !empty;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: a standard-read FIFO (DEPTH 8) and an FWFT FIFO (DEPTH 5) checked
// against a queue model; a monitor pops stamped expectations each falling edge.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_flush, a_wr, a_rd;
    logic [15:0] a_din, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ack, a_ovf, a_udf;
    logic [3:0]  a_count;
    logic        b_flush, b_wr, b_rd;
    logic [15:0] b_din, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ack, b_ovf, b_udf;
    logic [2:0]  b_count;

    sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almostfull(a_af),
        .almostempty(a_ae), .count(a_count), .wr_ack(a_ack), .overflow(a_ovf),
        .underflow(a_udf)
    );

    sync_fifo_param #(.WIDTH(16), .DEPTH(5), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .flush(b_flush), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almostfull(b_af),
        .almostempty(b_ae), .count(b_count), .wr_ack(b_ack), .overflow(b_ovf),
        .underflow(b_udf)
    );

    typedef struct {
        int unsigned stamp;
        int          id;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] a_hold;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    string names [18] = '{"a_count", "a_full", "a_empty", "a_almostfull", "a_almostempty",
                          "a_wr_ack", "a_overflow", "a_underflow", "a_data_out", "b_count",
                          "b_full", "b_empty", "b_wr_ack", "b_overflow", "b_underflow",
                          "b_data_out", "b_almostfull", "b_almostempty"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(int id);
        case (id)
            0:       return 16'(a_count);
            1:       return 16'(a_full);
            2:       return 16'(a_empty);
            3:       return 16'(a_af);
            4:       return 16'(a_ae);
            5:       return 16'(a_ack);
            6:       return 16'(a_ovf);
            7:       return 16'(a_udf);
            8:       return a_dout;
            9:       return 16'(b_count);
            10:      return 16'(b_full);
            11:      return 16'(b_empty);
            12:      return 16'(b_ack);
            13:      return 16'(b_ovf);
            14:      return 16'(b_udf);
            15:      return b_dout;
            16:      return 16'(b_af);
            default: return 16'(b_ae);
        endcase
    endfunction

    task automatic chk(int id, logic [15:0] exp);
        logic [15:0] got;
        got = actual(id);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", names[id], cyc, got, exp);
        end
    endtask

    task automatic push(int id, logic [15:0] val);
        exp_t e;
        e.stamp = cyc + 1;
        e.id    = id;
        e.val   = val;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation whose target edge has passed.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            chk(exp_q[0].id, exp_q[0].val);
            void'(exp_q.pop_front());
        end
    end

    task automatic step_a(logic w, logic [15:0] d, logic r, logic f);
        int n0, n;
        logic wacc, racc, was_full;
        a_wr = w; a_din = d; a_rd = r; a_flush = f;
        b_wr = 1'b0; b_rd = 1'b0;
        n0 = qa.size();
        was_full = (n0 == 8);
        wacc = w && !was_full && !f;
        racc = r && (n0 > 0) && !f;
        if (f) begin
            qa.delete();
        end else begin
            if (racc) a_hold = qa.pop_front();
            if (wacc) qa.push_back(d);
        end
        n = qa.size();
        push(0, 16'(n));
        push(1, 16'(n == 8));
        push(2, 16'(n == 0));
        push(3, 16'(n >= 7 && n < 8));
        push(4, 16'(n == 1));
        push(5, 16'(wacc));
        push(6, 16'(w && was_full && !f));
        push(7, 16'(r && (n0 == 0) && !f));
        push(8, a_hold);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_b(logic w, logic [15:0] d, logic r);
        int n0, n;
        logic wacc, racc, was_full;
        b_wr = w; b_din = d; b_rd = r;
        a_wr = 1'b0; a_rd = 1'b0; a_flush = 1'b0;
        n0 = qb.size();
        was_full = (n0 == 5);
        wacc = w && !was_full;
        racc = r && (n0 > 0);
        if (racc) void'(qb.pop_front());
        if (wacc) qb.push_back(d);
        n = qb.size();
        push(9, 16'(n));
        push(10, 16'(n == 5));
        push(11, 16'(n == 0));
        push(12, 16'(wacc));
        push(13, 16'(w && was_full));
        push(14, 16'(r && (n0 == 0)));
        push(16, 16'(n == 4));
        push(17, 16'(n == 1));
        if (n > 0) push(15, qb[0]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_checks();
        chk(0, 16'h0); chk(1, 16'h0); chk(2, 16'h1); chk(3, 16'h0); chk(4, 16'h0);
        chk(5, 16'h0); chk(6, 16'h0); chk(7, 16'h0); chk(8, 16'h0);
        chk(9, 16'h0); chk(11, 16'h1); chk(12, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
        b_flush = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        a_hold = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks();
        rst = 1'b0;

        // Reset mid-traffic with five entries queued and a write pending.
        for (int i = 0; i < 5; i++) step_a(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        chk(0, 16'd5);
        a_wr = 1'b1; a_din = 16'h0105;
        #2 rst = 1'b1;
        #1 reset_checks();
        qa.delete(); qb.delete(); a_hold = '0;
        @(negedge clk);
        rst = 1'b0; a_wr = 1'b0;

        // Fill past full, then drain past empty.
        for (int i = 1; i <= 9; i++) step_a(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk(8, 16'h0008);
        chk(7, 16'h0001);

        // Simultaneous traffic at count 4, then at full, then at empty.
        for (int i = 0; i < 4; i++) step_a(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step_a(1'b1, 16'h0020 + 16'(i), 1'b1, 1'b0);
        chk(0, 16'd4);
        for (int i = 0; i < 4; i++) step_a(1'b1, 16'h0040 + 16'(i), 1'b0, 1'b0);
        step_a(1'b1, 16'h0050, 1'b1, 1'b0);
        chk(0, 16'd7);
        chk(6, 16'h0001);
        for (int i = 0; i < 7; i++) step_a(1'b0, 16'h0, 1'b1, 1'b0);
        step_a(1'b1, 16'h0060, 1'b1, 1'b0);
        chk(0, 16'd1);
        chk(7, 16'h0001);
        step_a(1'b0, 16'h0, 1'b1, 1'b0);

        // Flush wins over a concurrent write.
        for (int i = 0; i < 5; i++) step_a(1'b1, 16'h0070 + 16'(i), 1'b0, 1'b0);
        step_a(1'b1, 16'h7777, 1'b0, 1'b1);
        chk(0, 16'd0);
        chk(2, 16'h0001);
        chk(5, 16'h0000);
        step_a(1'b1, 16'hBEEF, 1'b0, 1'b0);
        step_a(1'b0, 16'h0, 1'b1, 1'b0);
        chk(8, 16'hBEEF);
        step_a(1'b0, 16'h0, 1'b0, 1'b0);

        // FWFT: zero-latency head, interleaved traffic across the wrap, then random.
        step_b(1'b1, 16'hA5A5, 1'b0);
        chk(15, 16'hA5A5);
        step_b(1'b0, 16'h0, 1'b0);
        step_b(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) step_b(1'b1, 16'h0200 + 16'(i), 1'((i % 3) != 0));
        for (int i = 0; i < 6; i++) step_b(1'b0, 16'h0, 1'b1);
        repeat (2000) step_b(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));

        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
